imem_boot_loader: RTL and testbench

Loads a program into the instruction memory from a byte stream, so the pipeline can run new test programs without a rebuild. A framed byte protocol is assembled into 32-bit words and written from word 0 upward. While a load is in progress the CPU is held and instruction fetch returns NOP. At the end of a load the block pulses a restart. It sits between the byte source (UART receiver or testbench), the instruction-memory write port and the fetch stage.

---
 rtl/imem_boot_loader.sv | 175 +++++++++++++++++
 tb/tb_imem_boot_loader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Byte-stream program loader for the instruction memory; holds the CPU while loading.
// Optional checksum byte per frame when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_boot_loader #(
    parameter int          ADDR_W    = 8,
    parameter logic [7:0]  HDR_BYTE  = 8'hA5,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       fetch_instr,
    output logic              cpu_hold,
    output logic              cpu_restart,
    output logic              load_done,
    output logic              load_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_BYTE,
        S_WRITE,
        S_FINISH,
        S_CSUM
    } state_t;

    state_t state, state_nxt;

    logic [7:0]        n_q;
    logic [7:0]        cnt_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [1:0]        bidx_q;
    logic [23:0]       word_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       wdata_q;
    logic              hold_q;
    logic              done_q;
    logic              xfer;
    logic              last_word;
    state_t            end_st;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum_q;
    logic       err_q;
    assign end_st   = S_CSUM;
    assign load_err = err_q;
`else
    assign end_st   = S_FINISH;
    assign load_err = 1'b0;
`endif

    assign xfer        = rx_valid & rx_ready;
    assign last_word   = (cnt_q + 8'd1) == n_q;
    assign mem_we      = (state == S_WRITE);
    assign cpu_restart = (state == S_FINISH);
    assign cpu_hold    = (state != S_IDLE) | hold_q;
    assign mem_waddr   = waddr_q;
    assign mem_wdata   = wdata_q;
    assign load_done   = done_q;
    assign fetch_instr = cpu_hold ? NOP_INSTR : imem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rx_ready  = 1'b1;
        unique case (state)
            S_IDLE: begin
                if (xfer && rx_data == HDR_BYTE) state_nxt = S_COUNT;
            end
            S_COUNT: begin
                if (xfer) state_nxt = (rx_data == 8'd0) ? end_st : S_BYTE;
            end
            S_BYTE: begin
                if (xfer && bidx_q == 2'd3) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                rx_ready  = 1'b0;
                state_nxt = last_word ? end_st : S_BYTE;
            end
            S_FINISH: begin
                rx_ready  = 1'b0;
                state_nxt = S_IDLE;
            end
            S_CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (xfer) state_nxt = (rx_data == csum_q) ? S_FINISH : S_IDLE;
`else
                state_nxt = S_IDLE;
`endif
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q     <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            bidx_q  <= '0;
            word_q  <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (xfer && rx_data == HDR_BYTE) begin
                        hold_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        err_q  <= 1'b0;
`endif
                    end
                end
                S_COUNT: begin
                    if (xfer) begin
                        n_q    <= rx_data;
                        cnt_q  <= '0;
                        ptr_q  <= '0;
                        bidx_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_q <= rx_data;
`endif
                    end
                end
                S_BYTE: begin
                    if (xfer) begin
                        bidx_q <= bidx_q + 2'd1;
                        word_q <= {rx_data, word_q[23:8]};
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ rx_data;
`endif
                        // capture on the 4th byte so the write port stays stable
                        if (bidx_q == 2'd3) begin
                            waddr_q <= ptr_q;
                            wdata_q <= {rx_data, word_q};
                        end
                    end
                end
                S_WRITE: begin
                    cnt_q <= cnt_q + 8'd1;
                    ptr_q <= ptr_q + ADDR_W'(1);
                end
                S_FINISH: begin
                    done_q <= 1'b1;
                end
                S_CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (xfer && rx_data != csum_q) begin
                        err_q  <= 1'b1;
                        hold_q <= 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed self-checking bench for imem_boot_loader.
// Small ADDR_W so that address wrap is reachable with a 5-word frame.
module tb_imem_boot_loader;

    localparam int          AW     = 2;
    localparam logic [31:0] NOP    = 32'h00000013;
    localparam logic [31:0] IMEM_V = 32'hDEADBEEF;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic [31:0]   imem_rdata;
    logic [31:0]   fetch_instr;
    logic          cpu_hold;
    logic          cpu_restart;
    logic          load_done;
    logic          load_err;

    imem_boot_loader #(.ADDR_W(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .mem_we      (mem_we),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .imem_rdata  (imem_rdata),
        .fetch_instr (fetch_instr),
        .cpu_hold    (cpu_hold),
        .cpu_restart (cpu_restart),
        .load_done   (load_done),
        .load_err    (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int rd    = 0;
    int base  = 0;
    logic [7:0] csum_sent;

    // monitor: records writes, restarts and protocol violations at negedge
    int          cyc = 0;
    int          last_acc = 0;
    int          last_we = 0;
    int          rs_cnt = 0;
    int          rs_we_lat = 0;
    int          rs_acc_lat = 0;
    logic        ready_bad = 1'b0;
    logic        nop_bad = 1'b0;
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          wl_q[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rx_valid && rx_ready) last_acc <= cyc;
        if (mem_we) begin
            wa_q.push_back(32'(mem_waddr));
            wd_q.push_back(mem_wdata);
            wl_q.push_back(cyc - last_acc);
            last_we <= cyc;
        end
        if (cpu_restart) begin
            rs_cnt     <= rs_cnt + 1;
            rs_we_lat  <= cyc - last_we;
            rs_acc_lat <= cyc - last_acc;
        end
        if (rx_ready && (mem_we || cpu_restart)) ready_bad <= 1'b1;
        if (cpu_hold && fetch_instr !== NOP) nop_bad <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic realign();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int t = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        while (!rx_ready && t < 40) begin
            t++;
            @(negedge clk);
        end
        if (t >= 40) chk("rx_timeout", 32'(rx_ready), 32'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_gap(input logic [7:0] b);
        send(b);
        realign();
    endtask

    task automatic frame_end(input logic [7:0] cs);
        csum_sent = cs;
        if (CS) send(csum_sent);
    endtask

    task automatic expect_write(input string tag, input logic [31:0] a,
                                input logic [31:0] d);
        chk({tag, "_present"}, 32'(wa_q.size() > rd), 32'd1);
        if (wa_q.size() > rd) begin
            chk({tag, "_addr"}, wa_q[rd], a);
            chk({tag, "_data"}, wd_q[rd], d);
            chk({tag, "_lat"}, wl_q[rd], 32'd1);
            rd++;
        end
    endtask

    task automatic wait_end();
        repeat (3) @(negedge clk);
        realign();
    endtask

    initial begin
        rst_n      = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        imem_rdata = IMEM_V;
        csum_sent  = 8'h00;
        realign();
        realign();

        chk("rst_ready", 32'(rx_ready), 32'd1);
        chk("rst_hold", 32'(cpu_hold), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_restart", 32'(cpu_restart), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_err", 32'(load_err), 32'd0);
        chk("rst_waddr", 32'(mem_waddr), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_fetch", fetch_instr, IMEM_V);
        rst_n = 1'b1;
        realign();

        // single-word frame
        base = rs_cnt;
        send(8'hA5);
        chk("t1_hold_cnt", 32'(cpu_hold), 32'd1);
        chk("t1_nop", fetch_instr, NOP);
        send(8'h01); send(8'h93); send(8'h00); send(8'hA0); send(8'h00);
        frame_end(8'h32);
        wait_end();
        expect_write("t1_w0", 32'd0, 32'h00A00093);
        chk("t1_restart", rs_cnt - base, 32'd1);
        chk("t1_rs_lat", CS ? rs_acc_lat : rs_we_lat, 32'd1);
        chk("t1_done", 32'(load_done), 32'd1);
        chk("t1_hold", 32'(cpu_hold), 32'd0);
        chk("t1_err", 32'(load_err), 32'd0);
        chk("t1_fetch", fetch_instr, IMEM_V);
        chk("t1_waddr_hold", 32'(mem_waddr), 32'd0);
        chk("t1_wdata_hold", mem_wdata, 32'h00A00093);

        // leading junk, two words
        base = rs_cnt;
        send(8'h7F); send(8'h12);
        chk("t2_idle_hold", 32'(cpu_hold), 32'd0);
        send(8'hA5);
        chk("t2_nop", fetch_instr, NOP);
        send(8'h02);
        send(8'h13); send(8'h01); send(8'h40); send(8'h01);
        send(8'hB3); send(8'h21); send(8'h11); send(8'h00);
        frame_end(8'hD2);
        wait_end();
        expect_write("t2_w0", 32'd0, 32'h01400113);
        expect_write("t2_w1", 32'd1, 32'h001121B3);
        chk("t2_nwr", wa_q.size(), rd);
        chk("t2_restart", rs_cnt - base, 32'd1);
        chk("t2_hold", 32'(cpu_hold), 32'd0);

        // reset mid-frame discards the partial word
        send(8'hA5); send(8'h01); send(8'h93); send(8'h00);
        chk("t3_hold_mid", 32'(cpu_hold), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t3_rst_ready", 32'(rx_ready), 32'd1);
        chk("t3_rst_hold", 32'(cpu_hold), 32'd0);
        chk("t3_rst_done", 32'(load_done), 32'd0);
        chk("t3_rst_wdata", mem_wdata, 32'd0);
        realign();
        rst_n = 1'b1;
        base = rs_cnt;
        send(8'hA5); send(8'h01);
        send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        frame_end(8'h12);
        wait_end();
        expect_write("t3_w0", 32'd0, 32'h00000013);
        chk("t3_nwr", wa_q.size(), rd);
        chk("t3_restart", rs_cnt - base, 32'd1);
        chk("t3_done", 32'(load_done), 32'd1);

        // empty frame
        base = rs_cnt;
        send(8'hA5); send(8'h00);
        frame_end(8'h00);
        wait_end();
        chk("t4_nwr", wa_q.size(), rd);
        chk("t4_restart", rs_cnt - base, 32'd1);
        chk("t4_rs_lat", rs_acc_lat, 32'd1);
        chk("t4_hold", 32'(cpu_hold), 32'd0);
        chk("t4_err", 32'(load_err), 32'd0);

        if (CS) begin
            base = rs_cnt;
            send(8'hA5); send(8'h00); send(8'h01);
            wait_end();
            chk("t4c_err", 32'(load_err), 32'd1);
            chk("t4c_hold", 32'(cpu_hold), 32'd1);
            chk("t4c_restart", rs_cnt - base, 32'd0);
            chk("t4c_done", 32'(load_done), 32'd1);
            send(8'hA5); send(8'h01); send(8'h93); send(8'h00);
            send(8'hA0); send(8'h00); send(8'h33);
            wait_end();
            expect_write("t5_w0", 32'd0, 32'h00A00093);
            chk("t5_err", 32'(load_err), 32'd1);
            chk("t5_hold", 32'(cpu_hold), 32'd1);
            chk("t5_restart", rs_cnt - base, 32'd0);
            send(8'hA5);
            chk("t5_err_clr", 32'(load_err), 32'd0);
            send(8'h00); send(8'h00);
            wait_end();
            chk("t5_retry_restart", rs_cnt - base, 32'd1);
            chk("t5_retry_hold", 32'(cpu_hold), 32'd0);
        end

        // gapped stream, header byte used as payload
        base = rs_cnt;
        send_gap(8'hA5); send_gap(8'h02);
        send_gap(8'h78); send_gap(8'h56); send_gap(8'h34); send_gap(8'h12);
        send_gap(8'hA5); send_gap(8'hA5); send_gap(8'hA5); send_gap(8'hA5);
        if (CS) send_gap(8'h0A);
        wait_end();
        expect_write("t6_w0", 32'd0, 32'h12345678);
        expect_write("t6_w1", 32'd1, 32'hA5A5A5A5);
        chk("t6_restart", rs_cnt - base, 32'd1);
        chk("t6_rs_lat", CS ? rs_acc_lat : rs_we_lat, 32'd1);

        // five words into a four-word memory: address wraps to 0
        base = rs_cnt;
        send(8'hA5); send(8'h05);
        for (int j = 1; j <= 5; j++) begin
            for (int k = 0; k < 4; k++) send(8'(j));
        end
        frame_end(8'h05);
        wait_end();
        expect_write("t7_w0", 32'd0, 32'h01010101);
        expect_write("t7_w1", 32'd1, 32'h02020202);
        expect_write("t7_w2", 32'd2, 32'h03030303);
        expect_write("t7_w3", 32'd3, 32'h04040404);
        expect_write("t7_w4", 32'd0, 32'h05050505);
        chk("t7_restart", rs_cnt - base, 32'd1);

        chk("ready_in_write_finish", 32'(ready_bad), 32'd0);
        chk("nop_while_held", 32'(nop_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
